// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI target receiver
package spi_pkg;
  localparam int SPI_BITS = 8;
  typedef struct packed {
    logic                dc;
    logic [SPI_BITS-1:0] data;
  } spi_rx_entry_t;
  typedef enum logic {IDLE, SHIFT} spi_state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO with registered push/pop, occupancy and full/empty flags
module spi_sync_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign empty  = level == '0;
  assign full   = level == (AW+1)'(DEPTH);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      level <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= din;
      r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd  <= w_pop ? r_rd + AW'(1) : r_rd;
      level <= level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/spi_target_rx.sv
// spi_target_rx: oversampled SPI mode-0 target receiving dc-tagged bytes into a FIFO with a miso reply shifter
module spi_target_rx
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX = 8'hFF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          sck,
  input  logic                          mosi,
  input  logic                          cs,
  input  logic                          dc,
  output logic                          miso,
  output logic                          miso_oe,
  output logic [7:0]                    rx_data,
  output logic                          rx_dc,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_load,
  output logic                          tx_ack,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          busy
);
  localparam int CW = $clog2(SPI_BITS);
  logic [SYNC_STAGES-1:0] r_sck_s, r_mosi_s, r_cs_s, r_dc_s;
  logic r_sck_d, r_cs_d;
  spi_state_t r_state, w_next;
  logic [CW-1:0] r_bit_cnt;
  logic [SPI_BITS-2:0] r_rx_sh;
  logic [SPI_BITS-1:0] r_tx_sh, r_pend_data, w_reply;
  logic r_pend, r_reload, r_tx_ack, r_frame_err, r_overflow;
  logic w_sck, w_mosi, w_cs, w_dc, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_in, w_rise, w_fall, w_done, w_reload, w_consume, w_frame_err;
  logic w_pop, w_full, w_empty;
  spi_rx_entry_t w_din, w_head;
  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_cs       = r_cs_s[SYNC_STAGES-1];
  assign w_dc       = r_dc_s[SYNC_STAGES-1];
  assign w_sck_rise = w_sck && !r_sck_d && !w_cs;
  assign w_sck_fall = !w_sck && r_sck_d && !w_cs;
  assign w_cs_fall  = !w_cs && r_cs_d;
  assign w_cs_rise  = w_cs && !r_cs_d;
  always_comb begin
    w_next      = r_state;
    w_next      = (r_state == IDLE && w_cs_fall) ? SHIFT : (r_state == SHIFT && w_cs_rise) ? IDLE : r_state;
    w_in        = r_state == SHIFT;
    w_rise      = w_in && w_sck_rise;
    w_fall      = w_in && w_sck_fall;
    w_done      = w_rise && r_bit_cnt == CW'(SPI_BITS-1);
    w_reload    = (!w_in && w_cs_fall) || (w_fall && r_reload);
    w_consume   = w_reload && r_pend;
    w_reply     = r_pend ? r_pend_data : IDLE_TX;
    w_frame_err = w_in && w_cs_rise && r_bit_cnt != '0;
  end
  assign w_din     = '{dc: w_dc, data: {r_rx_sh, w_mosi}};
  assign w_pop     = rx_valid && rx_ready;
  assign miso      = (r_state == SHIFT) ? r_tx_sh[SPI_BITS-1] : 1'b1;
  assign miso_oe   = !w_cs;
  assign busy      = !w_cs;
  assign rx_data   = w_head.data;
  assign rx_dc     = w_head.dc;
  assign rx_valid  = !w_empty;
  assign tx_ack    = r_tx_ack;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
  spi_sync_fifo #(.T(spi_rx_entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(!RESET),
    .push(w_done),
    .pop(w_pop),
    .din(w_din),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty),
    .level(level)
  );
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sck_s     <= '0;
      r_mosi_s    <= '0;
      r_cs_s      <= '1;
      r_dc_s      <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= IDLE_TX;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_reload    <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sck_s     <= {r_sck_s[SYNC_STAGES-2:0], sck};
      r_mosi_s    <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_cs_s      <= {r_cs_s[SYNC_STAGES-2:0], cs};
      r_dc_s      <= {r_dc_s[SYNC_STAGES-2:0], dc};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      r_state     <= w_next;
      r_bit_cnt   <= (w_in && !w_cs_rise) ? r_bit_cnt + CW'(w_rise) : '0;
      r_rx_sh     <= w_rise ? {r_rx_sh[SPI_BITS-3:0], w_mosi} : r_rx_sh;
      r_tx_sh     <= w_reload ? w_reply : w_fall ? {r_tx_sh[SPI_BITS-2:0], 1'b1} : r_tx_sh;
      r_reload    <= w_in && !w_cs_rise && (w_done || (r_reload && !w_fall));
      r_pend      <= tx_load || (r_pend && !w_consume);
      r_pend_data <= tx_load ? tx_data : r_pend_data;
      r_tx_ack    <= w_consume;
      r_frame_err <= w_frame_err;
      r_overflow  <= r_overflow || (w_done && w_full && !w_pop);
    end
  end
endmodule

// File: tb/tb_spi_target_rx.sv
// tb_spi_target_rx: table, directed and randomized checks of spi_target_rx against a queue-based reference
module tb_spi_target_rx;
  localparam int H = 3;
  localparam int SS = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic RESET, sck, mosi, cs, dc, rx_ready, tx_load;
  logic [7:0] tx_data;
  logic miso, miso_oe, rx_dc, rx_valid, tx_ack, overflow, frame_err, busy;
  logic [7:0] rx_data;
  logic [2:0] level;
  int checks = 0, errors = 0, cyc = 0, ack_cnt = 0, ferr_cnt = 0, vrise = -100, rise_cyc = 0;
  bit auto_pop = 0, prev_v = 0;
  logic [8:0] exp_q[$];
  typedef struct {
    logic [7:0] data;
    logic       dcv;
    logic       ld;
    logic [7:0] reply;
    logic [7:0] exp_rx;
    logic       exp_dc;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vecs[4];
  spi_target_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(SS), .IDLE_TX(8'hFF)) dut (
    .CLK(clk), .RESET(RESET), .sck(sck), .mosi(mosi), .cs(cs), .dc(dc),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ack(tx_ack), .level(level), .overflow(overflow), .frame_err(frame_err), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic spi_bits(input logic [7:0] d, input int n, input logic dcv, output logic [7:0] mb);
    mb = '1;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = d[i];
      dc = dcv;
      repeat (H) @(negedge clk);
      mb[i] = miso;
      sck = 1'b1;
      rise_cyc = cyc;
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic frame_begin();
    cs = 1'b0;
  endtask
  task automatic frame_end();
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (H + 4) @(negedge clk);
  endtask
  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask
  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(negedge clk);
    if (tx_ack) ack_cnt++;
    if (frame_err) ferr_cnt++;
    if (rx_valid && !prev_v) vrise = cyc;
    prev_v = rx_valid;
    if (auto_pop) begin
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_pop: got %0h expected nothing", {rx_dc, rx_data});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rand_pop", {rx_dc, rx_data}, e);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] mb, val;
    int a0, f0, nb;
    logic ld, dv;
    RESET = 1'b0; sck = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0;
    rx_ready = 1'b0; tx_load = 1'b0; tx_data = '0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 8'hFF};
    vecs[1] = '{8'h12, 1'b0, 1'b1, 8'h3C, 8'h12, 1'b0, 8'h3C};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 8'h00, 8'hF0, 1'b0, 8'hFF};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h81, 8'h00, 1'b1, 8'h81};
    repeat (3) @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_level", level, 0);
    check("rst_miso", miso, 1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", {rx_dc, rx_data}, 0);
    check("rst_tx_ack", tx_ack, 0);
    check("rst_frame_err", frame_err, 0);
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_miso", miso, 1);
    foreach (vecs[k]) begin
      a0 = ack_cnt;
      if (vecs[k].ld) load(vecs[k].reply);
      frame_begin();
      spi_bits(vecs[k].data, 8, vecs[k].dcv, mb);
      check("busy", busy, 1);
      check("miso_oe", miso_oe, 1);
      frame_end();
      check("latency", (vrise - rise_cyc >= 1) && (vrise - rise_cyc <= SS + 3), 1);
      check("tbl_valid", rx_valid, 1);
      check("tbl_data", rx_data, vecs[k].exp_rx);
      check("tbl_dc", rx_dc, vecs[k].exp_dc);
      check("tbl_level", level, 1);
      check("tbl_miso", mb, vecs[k].exp_miso);
      check("tbl_ack", ack_cnt - a0, vecs[k].ld ? 1 : 0);
      pop_one();
      check("tbl_level_pop", level, 0);
      check("tbl_valid_pop", rx_valid, 0);
    end
    a0 = ack_cnt;
    load(8'hAA);
    load(8'h55);
    frame_begin();
    spi_bits(8'h33, 8, 1'b0, mb);
    frame_end();
    check("overwrite_miso", mb, 8'h55);
    check("overwrite_ack", ack_cnt - a0, 1);
    check("overwrite_data", rx_data, 8'h33);
    pop_one();
    frame_begin();
    for (int b = 1; b <= 5; b++) spi_bits(8'(b), 8, 1'b0, mb);
    frame_end();
    check("full_level", level, 4);
    check("full_overflow", overflow, 1);
    for (int b = 1; b <= 4; b++) begin
      check("full_pop_data", rx_data, b);
      pop_one();
    end
    check("full_empty", rx_valid, 0);
    check("overflow_sticky", overflow, 1);
    f0 = ferr_cnt;
    frame_begin();
    repeat (H) @(negedge clk);
    frame_end();
    check("cs_only_ferr", ferr_cnt - f0, 0);
    check("cs_only_valid", rx_valid, 0);
    frame_begin();
    spi_bits(8'hB7, 5, 1'b0, mb);
    frame_end();
    check("partial_ferr", ferr_cnt - f0, 1);
    check("partial_level", level, 0);
    frame_begin();
    spi_bits(8'h7E, 8, 1'b1, mb);
    frame_end();
    check("after_partial_data", {rx_dc, rx_data}, 9'h17E);
    check("after_partial_ferr", ferr_cnt - f0, 1);
    pop_one();
    f0 = ferr_cnt;
    frame_begin();
    spi_bits(8'hFF, 4, 1'b1, mb);
    RESET = 1'b0;
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_level", level, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_busy", busy, 0);
    check("midrst_miso", miso, 1);
    check("midrst_valid", rx_valid, 0);
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    frame_begin();
    spi_bits(8'h81, 8, 1'b0, mb);
    frame_end();
    check("midrst_next_data", {rx_dc, rx_data}, 9'h081);
    check("midrst_next_ferr", ferr_cnt - f0, 0);
    pop_one();
    f0 = ferr_cnt;
    auto_pop = 1'b1;
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 3);
      ld = 1'($urandom_range(0, 1));
      val = 8'($urandom);
      if (ld) load(val);
      frame_begin();
      for (int j = 0; j < nb; j++) begin
        logic [7:0] d;
        d = 8'($urandom);
        dv = 1'($urandom_range(0, 1));
        exp_q.push_back({dv, d});
        spi_bits(d, 8, dv, mb);
        check("rand_miso", mb, (j == 0 && ld) ? val : 8'hFF);
      end
      frame_end();
    end
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
    check("rand_drain", exp_q.size(), 0);
    auto_pop = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_level", level, 0);
    check("rand_overflow", overflow, 0);
    check("rand_ferr", ferr_cnt - f0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
